// File: rtl/adc_trigger_avg.sv
// Paced ADC conversion sequencer: starts conversions on a programmable period tick,
// groups 2^k conversions per acquisition and pulses trigger when a group completes.
module adc_trigger_avg #(
    parameter int DIV_WIDTH    = 32,
    parameter int CNV_WIDTH    = 2,
    parameter int MAX_AVG_LOG2 = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic [31:0]          cfg,
    input  logic                 busy,
    input  logic                 ready,
    input  logic                 last,
    output logic                 cnv,
    output logic                 trigger,
    output logic                 active,
    output logic                 overrun,
    output logic                 timeout,
    output logic [31:0]          group_count
);

    localparam int TMR_MAX = (CNV_WIDTH > BUSY_TIMEOUT) ? CNV_WIDTH : BUSY_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CNT_W   = MAX_AVG_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE,
        CNV,
        WAIT_BUSY,
        WAIT_DONE,
        GAP,
        ACQ
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] period_q, period_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [CNT_W-1:0]     done_q, done_d;
    logic [3:0]           avg_q, avg_d;
    logic                 run_q, run_d;
    logic                 stop_pending_q, stop_pending_d;
    logic                 restart_q, restart_d;
    logic                 overrun_q, overrun_d;
    logic                 timeout_q, timeout_d;
    logic [31:0]          group_count_q, group_count_d;

    logic                 div_run;
    logic                 tick;
    logic                 restart_rise;
    logic                 start_group;
    logic                 group_full;
    logic                 cnv_done;
    logic                 busy_expired;
    logic [CNT_W-1:0]     group_size;
    logic                 unused_cfg;

    assign unused_cfg = ^{cfg[31:8], cfg[3:2]};

    always_comb begin
        div_run      = (divider >= DIV_WIDTH'(2));
        tick         = div_run && (period_q == '0);
        restart_rise = cfg[1] && !restart_q;
        start_group  = tick && run_q && !stop_pending_q && ready && !cfg[0];
        group_size   = CNT_W'(1) << avg_q;
        group_full   = (done_q + CNT_W'(1)) >= group_size;
        cnv_done     = (timer_q == TMR_W'(CNV_WIDTH - 1));
        busy_expired = (timer_q == TMR_W'(BUSY_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // GAP deliberately ignores ready and hold so a started group is never split.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_group) begin
                    state_d = CNV;
                end
            end
            CNV: begin
                if (cnv_done) begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (busy) begin
                    state_d = WAIT_DONE;
                end else if (busy_expired) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!busy) begin
                    state_d = group_full ? ACQ : GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = CNV;
                end
            end
            ACQ: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cnv     = (state_q == CNV);
        trigger = (state_q == ACQ);
        active  = (state_q != IDLE);
    end

    always_comb begin
        if (!div_run) begin
            period_d = '0;
        end else if (period_q == '0) begin
            period_d = divider - DIV_WIDTH'(1);
        end else begin
            period_d = period_q - DIV_WIDTH'(1);
        end

        // One timer serves both the cnv width and the busy timeout; it restarts on every state change.
        timer_d = '0;
        if ((state_d == state_q) && (state_q == CNV || state_q == WAIT_BUSY)) begin
            timer_d = timer_q + TMR_W'(1);
        end

        done_d = done_q;
        avg_d  = avg_q;
        if (state_q == IDLE && state_d == CNV) begin
            done_d = '0;
            avg_d  = (32'(cfg[7:4]) > MAX_AVG_LOG2) ? 4'(MAX_AVG_LOG2) : cfg[7:4];
        end else if (state_q == WAIT_DONE && !busy) begin
            done_d = done_q + CNT_W'(1);
        end

        run_d          = run_q;
        stop_pending_d = stop_pending_q || last;
        overrun_d      = overrun_q || (tick && (state_q inside {CNV, WAIT_BUSY, WAIT_DONE}));
        timeout_d      = timeout_q || (state_q == WAIT_BUSY && !busy && busy_expired);
        if (stop_pending_q && (state_q == IDLE || state_q == ACQ)) begin
            run_d          = 1'b0;
            stop_pending_d = last;
        end
        // A restart edge overrides a coincident last and clears the sticky errors.
        if (restart_rise) begin
            run_d          = 1'b1;
            stop_pending_d = 1'b0;
            overrun_d      = 1'b0;
            timeout_d      = 1'b0;
        end

        group_count_d = group_count_q;
        if (state_q == ACQ) begin
            group_count_d = group_count_q + 32'd1;
        end

        restart_d = cfg[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            period_q       <= '0;
            timer_q        <= '0;
            done_q         <= '0;
            avg_q          <= '0;
            run_q          <= 1'b1;
            stop_pending_q <= 1'b0;
            restart_q      <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
            group_count_q  <= '0;
        end else begin
            period_q       <= period_d;
            timer_q        <= timer_d;
            done_q         <= done_d;
            avg_q          <= avg_d;
            run_q          <= run_d;
            stop_pending_q <= stop_pending_d;
            restart_q      <= restart_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
            group_count_q  <= group_count_d;
        end
    end

    assign overrun     = overrun_q;
    assign timeout     = timeout_q;
    assign group_count = group_count_q;

endmodule

// File: tb/tb_adc_trigger_avg.sv
// Scoreboard bench for adc_trigger_avg: a behavioural ADC answers each cnv with a
// fixed busy pulse and predicts when each group's trigger must appear.
module tb_adc_trigger_avg;

    localparam int BUSY_TIMEOUT = 64;
    localparam int CNV_WIDTH    = 2;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] divider = '0;
    logic [31:0] cfg     = '0;
    logic        busy    = 1'b0;
    logic        ready   = 1'b0;
    logic        last    = 1'b0;
    logic        cnv;
    logic        trigger;
    logic        active;
    logic        overrun;
    logic        timeout;
    logic [31:0] group_count;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_trig_q[$];

    int group_n       = 1;
    bit busy_en       = 1'b1;
    int busy_len      = 14;
    int exp_period    = 0;
    int scen          = 0;
    bit forbid_cnv    = 1'b0;
    int rise_count    = 0;
    int last_rise_cyc = 0;

    adc_trigger_avg #(
        .DIV_WIDTH   (32),
        .CNV_WIDTH   (CNV_WIDTH),
        .MAX_AVG_LOG2(4),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .divider    (divider),
        .cfg        (cfg),
        .busy       (busy),
        .ready      (ready),
        .last       (last),
        .cnv        (cnv),
        .trigger    (trigger),
        .active     (active),
        .overrun    (overrun),
        .timeout    (timeout),
        .group_count(group_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        n_checks++;
        if (observed == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] div_v, input logic [31:0] cfg_v, input logic ready_v);
        divider = div_v;
        cfg     = cfg_v;
        ready   = ready_v;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while ((active || busy || exp_trig_q.size() != 0) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        checkOutput(tag, longint'(active || busy || exp_trig_q.size() != 0), 0);
    endtask

    task automatic wait_rises(input int target, input int budget, input string tag);
        int i = 0;
        while (rise_count < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput(tag, longint'(rise_count >= target), 1);
    endtask

    // ADC model and output monitor share one process so busy updates and checks are ordered.
    initial begin : adc_model
        int busy_left       = 0;
        bit cnv_prev        = 1'b0;
        bit timeout_prev    = 1'b0;
        bit prev_valid      = 1'b0;
        bit ignore_inflight = 1'b0;
        int prev_rise       = 0;
        int fall_cyc        = 0;
        int conv_in_group   = 0;
        int last_scen       = 0;
        forever begin
            @(negedge clk);
            #1;
            if (scen != last_scen) begin
                prev_valid = 1'b0;
                last_scen  = scen;
            end
            if (reset) begin
                conv_in_group   = 0;
                ignore_inflight = busy;
                cnv_prev        = 1'b0;
                timeout_prev    = 1'b0;
            end else begin
                if (trigger) begin
                    if (exp_trig_q.size() == 0) checkOutput("trig_unexpected", 1, 0);
                    else checkOutput("trig_cycle", cyc, exp_trig_q.pop_front());
                end
                if (cnv && !cnv_prev) begin
                    rise_count++;
                    last_rise_cyc = cyc;
                    if (prev_valid && exp_period != 0) checkOutput("cnv_period", cyc - prev_rise, exp_period);
                    if (busy) checkOutput("cnv_while_busy", 1, 0);
                    if (forbid_cnv) checkOutput("cnv_forbidden", 1, 0);
                    prev_rise  = cyc;
                    prev_valid = 1'b1;
                end
                if (timeout && !timeout_prev) checkOutput("timeout_latency", cyc - fall_cyc, BUSY_TIMEOUT);
                timeout_prev = timeout;
            end
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    busy = 1'b0;
                    if (ignore_inflight) begin
                        ignore_inflight = 1'b0;
                    end else begin
                        conv_in_group++;
                        if (conv_in_group == group_n) begin
                            exp_trig_q.push_back(cyc + 1);
                            conv_in_group = 0;
                        end
                    end
                end
            end
            if (!reset && !cnv && cnv_prev) begin
                checkOutput("cnv_width", cyc - prev_rise, CNV_WIDTH);
                fall_cyc = cyc;
                if (busy_en) begin
                    busy      = 1'b1;
                    busy_left = busy_len;
                end
            end
            if (!reset) cnv_prev = cnv;
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 300000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int base;
        int base2;
        int t0;
        int gc0;

        applyReset();
        checkOutput("rst_cnv", cnv, 0);
        checkOutput("rst_trigger", trigger, 0);
        checkOutput("rst_active", active, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_group_count", group_count, 0);

        // ready held low: ticks must be dropped, then pacing resumes at 50 cycles
        scen = 1; group_n = 1; exp_period = 50;
        applyStimulus(50, 32'h0, 1'b0);
        forbid_cnv = 1'b1;
        base = rise_count;
        repeat (200) @(negedge clk);
        checkOutput("no_cnv_ready0", rise_count - base, 0);
        forbid_cnv = 1'b0;
        ready = 1'b1;
        t0 = cyc;
        wait_rises(base + 1, 60, "first_cnv_after_ready");
        checkOutput("ready_to_cnv_le51", longint'((last_rise_cyc - t0) <= 51), 1);
        wait_rises(base + 4, 250, "cnv_run_033");
        ready = 1'b0;
        wait_idle("idle_033");
        checkOutput("overrun_033", overrun, 0);

        // group of four conversions, one trigger
        applyReset();
        scen = 2; group_n = 4; exp_period = 50;
        applyStimulus(50, 32'h20, 1'b1);
        base = rise_count;
        for (int i = 0; i < 400 && group_count != 32'd1; i++) @(negedge clk);
        ready = 1'b0;
        checkOutput("group_count_034", group_count, 1);
        checkOutput("cnv_per_group_034", rise_count - base, 4);
        wait_idle("idle_034");

        // period shorter than a conversion: overrun, every other tick used
        applyReset();
        scen = 3; group_n = 1; exp_period = 20;
        applyStimulus(10, 32'h0, 1'b1);
        base = rise_count;
        wait_rises(base + 4, 200, "cnv_run_035");
        checkOutput("overrun_035", overrun, 1);
        ready = 1'b0;
        wait_idle("idle_035");

        // last mid-group, then restart
        scen = 4; group_n = 4; exp_period = 0;
        gc0 = group_count;
        applyStimulus(50, 32'h20, 1'b1);
        base = rise_count;
        wait_rises(base + 2, 200, "mid_group_036");
        last = 1'b1;
        @(negedge clk);
        last = 1'b0;
        for (int i = 0; i < 400 && !(rise_count >= base + 4 && !active); i++) @(negedge clk);
        checkOutput("group_after_last", group_count, gc0 + 1);
        forbid_cnv = 1'b1;
        base2 = rise_count;
        repeat (400) @(negedge clk);
        checkOutput("no_cnv_after_last", rise_count - base2, 0);
        checkOutput("overrun_sticky", overrun, 1);
        forbid_cnv = 1'b0;
        cfg = 32'h22;
        t0 = cyc;
        @(negedge clk);
        cfg = 32'h20;
        wait_rises(base2 + 1, 60, "cnv_after_restart");
        checkOutput("restart_to_cnv_le51", longint'((last_rise_cyc - t0) <= 51), 1);
        checkOutput("overrun_cleared", overrun, 0);
        ready = 1'b0;
        wait_idle("idle_036");

        // ADC never answers: timeout, group aborted, next cnv two ticks later
        applyReset();
        scen = 5; group_n = 1; exp_period = 100; busy_en = 1'b0;
        applyStimulus(50, 32'h0, 1'b1);
        base = rise_count;
        wait_rises(base + 3, 400, "cnv_run_037");
        checkOutput("timeout_037", timeout, 1);
        checkOutput("no_group_037", group_count, 0);
        ready = 1'b0;
        wait_idle("idle_037");
        busy_en = 1'b1;

        // averaging exponent above the clamp, then a stopped divider
        applyReset();
        scen = 6; group_n = 16; exp_period = 20;
        applyStimulus(20, 32'h70, 1'b1);
        base = rise_count;
        for (int i = 0; i < 500 && group_count != 32'd1; i++) @(negedge clk);
        ready = 1'b0;
        checkOutput("group_count_clamp", group_count, 1);
        checkOutput("cnv_per_group_clamp", rise_count - base, 16);
        wait_idle("idle_clamp");
        applyStimulus(1, 32'h0, 1'b1);
        forbid_cnv = 1'b1;
        base = rise_count;
        repeat (200) @(negedge clk);
        checkOutput("no_cnv_div1", rise_count - base, 0);
        forbid_cnv = 1'b0;
        ready = 1'b0;

        // reset while the DUT waits for busy to fall
        applyReset();
        scen = 7; group_n = 4; exp_period = 50;
        applyStimulus(50, 32'h20, 1'b1);
        for (int i = 0; i < 100 && !(busy && active); i++) @(negedge clk);
        checkOutput("in_wait_done", longint'(busy && active), 1);
        @(negedge clk);
        ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_mid_cnv", cnv, 0);
        checkOutput("rst_mid_trigger", trigger, 0);
        checkOutput("rst_mid_active", active, 0);
        checkOutput("rst_mid_overrun", overrun, 0);
        checkOutput("rst_mid_timeout", timeout, 0);
        checkOutput("rst_mid_group_count", group_count, 0);
        wait_idle("idle_038");
        repeat (20) @(negedge clk);
        checkOutput("group_count_after_abort", group_count, 0);

        checkOutput("scoreboard_drained", exp_trig_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
